// File: rtl/pulse_meas.sv
// Pulse width/period meter; results via vld/ack handshake, sticky ovr/err, wrapping cycle count.
// Define PULSE_MEAS_SYNC_EN to add a 2-flop input synchroniser on sig (edge detection 1 cycle later).
module pulse_meas #(
    parameter int MSB      = 7,
    parameter int CYCLEMSB = 3
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              setb,
    input  logic              v1,
    input  logic              sig,
    input  logic              halt,
    input  logic              haltena,
    input  logic              ack,
    output logic [MSB:0]      pw,
    output logic [MSB:0]      period,
    output logic              vld,
    output logic              ovr,
    output logic              err,
    output logic              busy,
    output logic [CYCLEMSB:0] cycle
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam logic [MSB:0]      CNT_MAX = '1;
    localparam logic [MSB:0]      CNT_ONE = {{MSB{1'b0}}, 1'b1};
    localparam logic [CYCLEMSB:0] CYC_ONE = {{CYCLEMSB{1'b0}}, 1'b1};

    state_t       state;
    state_t       state_nx;
    logic [MSB:0] cnt;
    logic [MSB:0] cnt_nx;
    logic [MSB:0] cnt_inc;
    logic [MSB:0] pw_r;
    logic         s;
    logic         s_d;
    logic         frozen;
    logic         run;
    logic         act_e;
    logic         idl_e;
    logic         cap_pw;
    logic         done;
    logic         tmo;

    // setb low keeps sampling alive so no stale edge is seen on re-enable
    assign frozen = setb && halt && haltena;
    assign run    = setb && !(halt && haltena);

`ifdef PULSE_MEAS_SYNC_EN
    logic sync1;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            sync1 <= v1;
            s     <= v1;
            s_d   <= v1;
        end else if (!frozen) begin
            sync1 <= sig;
            s     <= sync1;
            s_d   <= s;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rstb) begin
            s   <= v1;
            s_d <= v1;
        end else if (!frozen) begin
            s   <= sig;
            s_d <= s;
        end
    end
`endif

    assign act_e   = (s == ~v1) && (s_d == v1);
    assign idl_e   = (s == v1) && (s_d == ~v1);
    assign busy    = (state == HIGH) || (state == LOW);
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cap_pw   = 1'b0;
        done     = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx   = '0;
                state_nx = ARM;
            end
            ARM: begin
                if (act_e) begin
                    cnt_nx   = CNT_ONE;
                    state_nx = HIGH;
                end
            end
            HIGH: begin
                if (idl_e) begin
                    cap_pw   = 1'b1;
                    cnt_nx   = cnt_inc;
                    state_nx = LOW;
                end else if (cnt == CNT_MAX) begin
                    tmo      = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ARM;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            LOW: begin
                if (act_e) begin
                    done     = 1'b1;
                    cnt_nx   = CNT_ONE;
                    state_nx = HIGH;
                end else if (cnt == CNT_MAX) begin
                    tmo      = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ARM;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state  <= IDLE;
            cnt    <= '0;
            pw_r   <= '0;
            pw     <= '0;
            period <= '0;
            cycle  <= '0;
            vld    <= 1'b0;
            ovr    <= 1'b0;
            err    <= 1'b0;
        end else if (!setb) begin
            state <= IDLE;
            cnt   <= '0;
            cycle <= '0;
            vld   <= 1'b0;
            ovr   <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (run) begin
                state <= state_nx;
                cnt   <= cnt_nx;
                if (cap_pw) begin
                    pw_r <= cnt;
                end
                if (tmo) begin
                    err <= 1'b1;
                end
                if (done) begin
                    period <= cnt;
                    pw     <= pw_r;
                    cycle  <= cycle + CYC_ONE;
                end
            end
            // A new result always wins over ack; it is an overrun only if the old one was not taken
            if (run && done) begin
                vld <= 1'b1;
                if (vld && !ack) begin
                    ovr <= 1'b1;
                end
            end else if (ack) begin
                vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_meas.sv
// Directed bench for pulse_meas: a monitor pops expected results on each completed measurement.
module tb_pulse_meas;

    localparam int MSB  = 7;
    localparam int CMSB = 3;
`ifdef PULSE_MEAS_SYNC_EN
    localparam int SLAT = 2;
`else
    localparam int SLAT = 1;
`endif

    typedef struct packed {
        logic [MSB:0]  pw;
        logic [MSB:0]  per;
        logic [CMSB:0] cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstb;
    logic          setb;
    logic          v1;
    logic          sig;
    logic          halt;
    logic          haltena;
    logic          ack;
    logic          mon_ack;
    logic          stim_ack;
    logic          auto_ack;
    logic [MSB:0]  pw;
    logic [MSB:0]  period;
    logic          vld;
    logic          ovr;
    logic          err;
    logic          busy;
    logic [CMSB:0] cycle;

    int            n_vec = 0;
    int            n_err = 0;
    logic [CMSB:0] exp_cycle;
    exp_t          q[$];

    assign ack = mon_ack | stim_ack;

    always #5 clk = ~clk;

    pulse_meas #(.MSB(MSB), .CYCLEMSB(CMSB)) dut (
        .clk     (clk),
        .rstb    (rstb),
        .setb    (setb),
        .v1      (v1),
        .sig     (sig),
        .halt    (halt),
        .haltena (haltena),
        .ack     (ack),
        .pw      (pw),
        .period  (period),
        .vld     (vld),
        .ovr     (ovr),
        .err     (err),
        .busy    (busy),
        .cycle   (cycle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input int epw, input int eper);
        exp_t e;
        exp_cycle = exp_cycle + 4'd1;
        e.pw  = MSB'(epw);
        e.per = MSB'(eper);
        e.cyc = exp_cycle;
        q.push_back(e);
    endtask

    // Active level for a cycles, then idle level for i cycles; optional ack on the closing edge
    task automatic pulse(input int a, input int i, input bit ackc);
        sig = ~v1;
        if (ackc) begin
            repeat (SLAT) tick();
            stim_ack = 1'b1;
            tick();
            stim_ack = 1'b0;
            repeat (a - SLAT - 1) tick();
        end else begin
            repeat (a) tick();
        end
        sig = v1;
        repeat (i) tick();
    endtask

    task automatic restart(input logic pol);
        setb = 1'b0;
        v1   = pol;
        sig  = pol;
        repeat (3) tick();
        setb      = 1'b1;
        exp_cycle = '0;
        repeat (3) tick();
    endtask

    task automatic drain(input string name);
        repeat (12) tick();
        chk(name, 32'(q.size()), 0);
    endtask

    // Monitor: a completed measurement shows up as cycle advancing by one
    initial begin
        logic [CMSB:0] prev_cycle;
        exp_t          e;
        prev_cycle = '0;
        mon_ack    = 1'b0;
        forever begin
            @(negedge clk);
            if (rstb && setb && cycle == CMSB'(prev_cycle + 4'd1)) begin
                prev_cycle = cycle;
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'(cycle), 0);
                end else begin
                    e = q.pop_front();
                    chk("res_pw",     32'(pw),     32'(e.pw));
                    chk("res_period", 32'(period), 32'(e.per));
                    chk("res_cycle",  32'(cycle),  32'(e.cyc));
                end
                if (auto_ack) begin
                    mon_ack = 1'b1;
                    @(negedge clk);
                    mon_ack = 1'b0;
                end
            end else begin
                prev_cycle = cycle;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got %0d vectors, expected completion", n_vec);
        $fatal(1, "bench timeout");
    end

    initial begin
        rstb      = 1'b0;
        setb      = 1'b0;
        v1        = 1'b0;
        sig       = 1'b0;
        halt      = 1'b0;
        haltena   = 1'b0;
        stim_ack  = 1'b0;
        auto_ack  = 1'b1;
        exp_cycle = '0;
        repeat (2) tick();
        chk("rst_pw",     32'(pw),     0);
        chk("rst_period", 32'(period), 0);
        chk("rst_vld",    32'(vld),    0);
        chk("rst_ovr",    32'(ovr),    0);
        chk("rst_err",    32'(err),    0);
        chk("rst_busy",   32'(busy),   0);
        chk("rst_cycle",  32'(cycle),  0);
        rstb = 1'b1;

        // Basic: 3 high / 5 low repeating
        restart(1'b0);
        pulse(3, 5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            expect_res(3, 8);
            pulse(3, 5, 1'b0);
        end
        drain("basic_drain");
        chk("basic_vld_acked", 32'(vld), 0);
        chk("basic_ovr",       32'(ovr), 0);

        // Inverted polarity: 4 low / 6 high
        restart(1'b1);
        pulse(4, 6, 1'b0);
        for (int k = 0; k < 2; k++) begin
            expect_res(4, 10);
            pulse(4, 6, 1'b0);
        end
        drain("inv_drain");

        // Handshake and overrun, consumer driven by hand
        restart(1'b0);
        auto_ack = 1'b0;
        pulse(3, 5, 1'b0);
        expect_res(3, 8);
        pulse(3, 5, 1'b0);
        chk("hs_vld_first", 32'(vld), 1);
        expect_res(3, 8);
        pulse(3, 5, 1'b1);
        chk("hs_ackcomp_vld", 32'(vld), 1);
        chk("hs_ackcomp_ovr", 32'(ovr), 0);
        stim_ack = 1'b1;
        tick();
        stim_ack = 1'b0;
        chk("hs_ack_clears_vld", 32'(vld), 0);
        expect_res(3, 9);
        pulse(2, 4, 1'b0);
        chk("hs_no_ovr", 32'(ovr), 0);
        expect_res(2, 6);
        pulse(3, 5, 1'b0);
        chk("ovr_set",   32'(ovr), 1);
        chk("ovr_vld",   32'(vld), 1);
        chk("ovr_pw",    32'(pw), 2);
        chk("ovr_per",   32'(period), 6);
        chk("ovr_busy",  32'(busy), 1);
        chk("ovr_drain", 32'(q.size()), 0);

        // Disable mid-measurement
        setb = 1'b0;
        tick();
        chk("dis_busy",   32'(busy),   0);
        chk("dis_vld",    32'(vld),    0);
        chk("dis_ovr",    32'(ovr),    0);
        chk("dis_err",    32'(err),    0);
        chk("dis_cycle",  32'(cycle),  0);
        chk("dis_pw",     32'(pw),     2);
        chk("dis_period", 32'(period), 6);
        auto_ack = 1'b1;

        // Timeout: active level held past counter saturation
        restart(1'b0);
        sig = 1'b1;
        repeat (200) tick();
        chk("tmo_err_early",  32'(err),  0);
        chk("tmo_busy_early", 32'(busy), 1);
        repeat (100) tick();
        chk("tmo_err",  32'(err),  1);
        chk("tmo_busy", 32'(busy), 0);
        sig = 1'b0;
        repeat (3) tick();
        pulse(3, 5, 1'b0);
        expect_res(3, 8);
        pulse(3, 5, 1'b0);
        drain("tmo_drain");
        chk("tmo_err_sticky", 32'(err), 1);
        setb = 1'b0;
        tick();
        chk("tmo_err_clear", 32'(err), 0);

        // Halt for 4 cycles inside a 7-cycle high phase looks like a 3/5 pulse
        restart(1'b0);
        sig = 1'b1;
        repeat (3) tick();
        halt    = 1'b1;
        haltena = 1'b1;
        repeat (4) tick();
        chk("halt_busy", 32'(busy), 1);
        halt    = 1'b0;
        haltena = 1'b0;
        sig     = 1'b0;
        repeat (5) tick();
        expect_res(3, 8);
        pulse(3, 5, 1'b0);
        halt = 1'b1;
        expect_res(3, 8);
        pulse(3, 5, 1'b0);
        expect_res(3, 8);
        pulse(3, 5, 1'b0);
        halt = 1'b0;
        drain("halt_drain");

        // Reset mid-operation
        restart(1'b0);
        pulse(3, 5, 1'b0);
        expect_res(3, 8);
        pulse(3, 5, 1'b0);
        sig = 1'b1;
        repeat (2) tick();
        chk("pre_rst_pw", 32'(pw), 3);
        rstb = 1'b0;
        tick();
        chk("mid_rst_pw",     32'(pw),     0);
        chk("mid_rst_period", 32'(period), 0);
        chk("mid_rst_cycle",  32'(cycle),  0);
        chk("mid_rst_vld",    32'(vld),    0);
        chk("mid_rst_busy",   32'(busy),   0);
        chk("mid_rst_drain",  32'(q.size()), 0);
        rstb = 1'b1;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_meas.md
Name: pulse_meas

Overview:
Pulse measurement stage that sits directly downstream of the pulse generator; its input is the generator's cko output, or any external pulse train.
- Measures the active-level width and the period of the incoming waveform, in clk cycles.
- Delivers each result with a valid/ack handshake.
- Flags overrun and timeout.
- Keeps a completed-measurement count, so generator output can be checked in-system against programmed pw/period.

Parameters:
MSB, 7, MSB of the width/period counters and result registers (counters are MSB+1 bits).
CYCLEMSB, 3, MSB of the completed-measurement counter.

Ports:
clk  input  1  system clock; all logic on posedge clk.
rstb  input  1  reset, synchronous, active-low, sampled on posedge clk.
setb  input  1  enable; low holds the block idle and clears status.
v1  input  1  idle level of sig; the active level is ~v1.
sig  input  1  waveform to measure.
halt  input  1  halt request.
haltena  input  1  halt enable; halt&&haltena freezes measurement.
ack  input  1  consumer acknowledge of current result.
pw  output  MSB+1  last measured active width, in cycles.
period  output  MSB+1  last measured period (active edge to next active edge), in cycles.
vld  output  1  result pending.
ovr  output  1  sticky overrun.
err  output  1  sticky timeout (counter saturated).
busy  output  1  state is HIGH or LOW.
cycle  output  CYCLEMSB+1  completed measurements, wraps.

Behaviour:
- Reset (rstb=0 at posedge): state=IDLE; cnt, pw_r, pw, period and cycle all 0; vld, ovr and err 0; sample regs loaded with v1.
- Sampling:
  - s is sig after the optional synchroniser; s_d is s delayed one cycle.
  - act_e = (s==~v1)&&(s_d==v1).
  - idl_e = (s==v1)&&(s_d==~v1).
  - act_e and idl_e are mutually exclusive by construction.
- State machine (advances only when setb=1 and not (halt&&haltena)):
  - IDLE: cnt=0; go to ARM.
  - ARM: wait for act_e, with no timeout. On act_e: cnt<=1, go to HIGH.
  - HIGH: cnt<=cnt+1 each cycle.
    - On idl_e: pw_r<=cnt, go to LOW, cnt<=cnt+1.
    - If cnt==all-ones without idl_e: err<=1, cnt<=0, go to ARM.
  - LOW: cnt<=cnt+1 each cycle.
    - On act_e: period<=cnt, pw<=pw_r, vld<=1, cycle<=cycle+1 (wraps), cnt<=1, go to HIGH. Measurements continue back-to-back.
    - If cnt==all-ones: err<=1, cnt<=0, go to ARM.
- Latency: a signal active for P cycles gives pw=P; active edges T cycles apart give period=T. Results are registered on the posedge that detects the closing act_e.
- Halt (halt&&haltena with setb=1): state, cnt and sample regs frozen. Edges during halt are lost. The ack handshake still operates.
- Handshake:
  - ack while vld=1 clears vld on the next edge.
  - Completion in the same cycle as ack: vld stays 1 with the new data, ovr unchanged.
  - Completion while vld=1 and no ack: ovr<=1, data overwritten, vld stays 1.
  - ack while vld=0 has no effect.
- setb=0 (any state, including mid-measurement): next edge state=IDLE; cnt, cycle, vld, ovr and err cleared; pw/period hold their last values.
- rstb has priority over setb. setb has priority over halt.
- err does not stop operation after ARM re-entry. It is cleared only by setb=0 or reset.
- Arithmetic: unsigned MSB+1 bit. cnt never wraps (saturation is detected at all-ones). cycle wraps modulo 2^(CYCLEMSB+1).
- busy = (state==HIGH)||(state==LOW).

Optional Feature:
PULSE_MEAS_SYNC_EN
- Defined: sig passes through a 2-flop synchroniser (reset to v1) before s. Edge detection is 2 cycles later; widths and periods are unchanged.
- Undefined: s=sig registered once (async sig is not allowed). Edge detection is 1 cycle after the sig change.

Test Plan:
- Basic measurement, v1=0, MSB=7: sig high 3 cycles / low 5 cycles repeating, setb=1 -> after the 2nd rising edge vld=1, pw=3, period=8, cycle=1; following results identical, cycle increments each period.
- Inverted polarity: v1=1, sig low 4 / high 6 -> pw=4, period=10.
- Handshake and overrun: no ack across two completions -> ovr=1 and pw/period show the 2nd result. ack pulsed in the same cycle as a completion -> vld stays 1, ovr stays 0. ack alone -> vld=0 next cycle.
- Timeout: MSB=7, sig held active after an active edge -> err=1 when cnt reaches 255, state ARM, busy=0. Next full pulse measured normally, err still 1 until setb low.
- Halt: halt=haltena=1 for 4 cycles inside the high phase of a 3/5 pulse -> no state/cnt change during halt; halt=1 with haltena=0 -> pw=3, period=8 unaffected.
- Reset/disable mid-op: setb low during LOW -> next cycle busy=0, vld=ovr=err=cycle=0, pw/period held. rstb low -> all outputs 0 on the next posedge.
